conv_loop_scheduler: RTL and testbench

// - Synchronous loop-nest sequencer for one convolution layer on the MAC array.
// - Generates the tile and kernel indices O_CH_MAC_COL, I_CH_MAC_ROW, W_W and W_H. These feed WeightController and IFMapController.
// - Issues one weight-controller start pulse per pass. A pass is one O_CH tile x I_CH tile x kernel tap.
// - Steps the indices when the ifmap side reports the pass complete, and flags the end of the layer.

---
 rtl/conv_loop_scheduler_if.sv | 39 +++
 rtl/conv_loop_scheduler.sv | 135 +++++++++++++
 tb/tb_conv_loop_scheduler.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/conv_loop_scheduler_if.sv
// rtl/conv_loop_scheduler_if.sv - handshake and index bundle between the loop scheduler and its host (optional flags: LOOP_ACC_FLAG_EN)
interface conv_loop_scheduler_if #(
  parameter int CNT_BIT = 32
);
  logic               start_in;
  logic               abort_in;
  logic               pass_done_in;
  logic               w_start_out;
  logic [CNT_BIT-1:0] O_CH_MAC_COL_count;
  logic [CNT_BIT-1:0] I_CH_MAC_ROW_count;
  logic [CNT_BIT-1:0] W_W_count;
  logic [CNT_BIT-1:0] W_H_count;
  logic               busy_out;
  logic               done_out;
`ifdef LOOP_ACC_FLAG_EN
  logic               acc_first_out;
  logic               acc_last_out;
`endif

  // host side: issues layer commands and pass completions
  modport master (
    output start_in, abort_in, pass_done_in,
    input  w_start_out, O_CH_MAC_COL_count, I_CH_MAC_ROW_count,
    input  W_W_count, W_H_count, busy_out, done_out
`ifdef LOOP_ACC_FLAG_EN
    , input acc_first_out, acc_last_out
`endif
  );

  // scheduler side
  modport slave (
    input  start_in, abort_in, pass_done_in,
    output w_start_out, O_CH_MAC_COL_count, I_CH_MAC_ROW_count,
    output W_W_count, W_H_count, busy_out, done_out
`ifdef LOOP_ACC_FLAG_EN
    , output acc_first_out, acc_last_out
`endif
  );
endinterface

// File: rtl/conv_loop_scheduler.sv
// rtl/conv_loop_scheduler.sv - convolution loop-nest sequencer: O_CH/I_CH/W_W/W_H odometer, one weight start per pass (optional psum flags: LOOP_ACC_FLAG_EN)
module conv_loop_scheduler #(
  parameter int MAC_ROW           = 16,
  parameter int MAC_COL           = 16,
  parameter int OFMAP_CHANNEL_NUM = 64,
  parameter int IFMAP_CHANNEL_NUM = 32,
  parameter int WEIGHT_WIDTH      = 3,
  parameter int WEIGHT_HEIGHT     = 3,
  parameter int CNT_BIT           = 32
) (
  input  logic                   clk,
  input  logic                   rstn,
  conv_loop_scheduler_if.slave   bus
);

  // last legal value of each index (limit - 1)
  localparam logic [CNT_BIT-1:0] NO_LAST = CNT_BIT'(OFMAP_CHANNEL_NUM / MAC_COL - 1);
  localparam logic [CNT_BIT-1:0] NI_LAST = CNT_BIT'(IFMAP_CHANNEL_NUM / MAC_ROW - 1);
  localparam logic [CNT_BIT-1:0] NW_LAST = CNT_BIT'(WEIGHT_WIDTH - 1);
  localparam logic [CNT_BIT-1:0] NH_LAST = CNT_BIT'(WEIGHT_HEIGHT - 1);
  localparam logic [CNT_BIT-1:0] ONE     = CNT_BIT'(1);
  localparam logic [CNT_BIT-1:0] ZERO    = '0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_BIT-1:0] o_ch_q, o_ch_d;
  logic [CNT_BIT-1:0] i_ch_q, i_ch_d;
  logic [CNT_BIT-1:0] w_w_q,  w_w_d;
  logic [CNT_BIT-1:0] w_h_q,  w_h_d;

  logic o_wrap, i_wrap, w_wrap, h_wrap, last_pass;

  // an index at its last value counts as wrapped; a limit of 1 is always wrapped
  always_comb begin
    o_wrap    = (o_ch_q == NO_LAST);
    i_wrap    = (i_ch_q == NI_LAST);
    w_wrap    = (w_w_q  == NW_LAST);
    h_wrap    = (w_h_q  == NH_LAST);
    last_pass = o_wrap && i_wrap && w_wrap && h_wrap;
  end

  // state and index registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      o_ch_q  <= '0;
      i_ch_q  <= '0;
      w_w_q   <= '0;
      w_h_q   <= '0;
    end else begin
      state_q <= state_d;
      o_ch_q  <= o_ch_d;
      i_ch_q  <= i_ch_d;
      w_w_q   <= w_w_d;
      w_h_q   <= w_h_d;
    end
  end

  // next state and odometer; abort overrides every other input
  always_comb begin
    state_d = state_q;
    o_ch_d  = o_ch_q;
    i_ch_d  = i_ch_q;
    w_w_d   = w_w_q;
    w_h_d   = w_h_q;
    if (bus.abort_in) begin
      state_d = IDLE;
      o_ch_d  = ZERO;
      i_ch_d  = ZERO;
      w_w_d   = ZERO;
      w_h_d   = ZERO;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.start_in) state_d = ISSUE;
        end
        ISSUE: begin
          state_d = WAIT;
        end
        WAIT: begin
          if (bus.pass_done_in) begin
            if (last_pass) begin
              state_d = DONE;
            end else begin
              state_d = ISSUE;
              // O_CH innermost, then I_CH, W_W, W_H
              o_ch_d = o_wrap ? ZERO : o_ch_q + ONE;
              if (o_wrap) begin
                i_ch_d = i_wrap ? ZERO : i_ch_q + ONE;
                if (i_wrap) begin
                  w_w_d = w_wrap ? ZERO : w_w_q + ONE;
                  if (w_wrap) w_h_d = h_wrap ? ZERO : w_h_q + ONE;
                end
              end
            end
          end
        end
        DONE: begin
          state_d = IDLE;
          o_ch_d  = ZERO;
          i_ch_d  = ZERO;
          w_w_d   = ZERO;
          w_h_d   = ZERO;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // pulses are masked by abort so nothing is issued in the abort cycle
  always_comb begin
    bus.w_start_out = (state_q == ISSUE) && !bus.abort_in;
    bus.done_out    = (state_q == DONE)  && !bus.abort_in;
    bus.busy_out    = (state_q == ISSUE) || (state_q == WAIT);
    bus.O_CH_MAC_COL_count = o_ch_q;
    bus.I_CH_MAC_ROW_count = i_ch_q;
    bus.W_W_count          = w_w_q;
    bus.W_H_count          = w_h_q;
  end

`ifdef LOOP_ACC_FLAG_EN
  // psum overwrite on the first reduction step, final on the last one
  always_comb begin
    bus.acc_first_out = bus.busy_out && (i_ch_q == ZERO) && (w_w_q == ZERO) && (w_h_q == ZERO);
    bus.acc_last_out  = bus.busy_out && i_wrap && w_wrap && h_wrap;
  end
`endif

endmodule

// File: tb/tb_conv_loop_scheduler.sv
// tb/tb_conv_loop_scheduler.sv - directed self-checking bench for conv_loop_scheduler
module tb_conv_loop_scheduler;

  logic clk;
  logic rstn;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   ws_count = 0;

  conv_loop_scheduler_if #(.CNT_BIT(32)) bus ();

  conv_loop_scheduler dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // counts every weight start pulse seen away from the active edge
  always @(negedge clk) begin
    if (bus.w_start_out === 1'b1) ws_count <= ws_count + 1;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    bus.start_in = 1'b0;
    bus.abort_in = 1'b0;
    bus.pass_done_in = 1'b0;
    #3;
    n_cmp++; if (bus.busy_out !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", bus.busy_out); end
    n_cmp++; if (bus.w_start_out !== 1'b0) begin n_bad++; $display("FAIL reset_wstart: got %b want 0", bus.w_start_out); end
    n_cmp++; if (bus.done_out !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b want 0", bus.done_out); end
    n_cmp++; if ({bus.O_CH_MAC_COL_count, bus.I_CH_MAC_ROW_count, bus.W_W_count, bus.W_H_count} !== 128'd0) begin
      n_bad++; $display("FAIL reset_counts: got %0d %0d %0d %0d want 0 0 0 0",
        bus.O_CH_MAC_COL_count, bus.I_CH_MAC_ROW_count, bus.W_W_count, bus.W_H_count);
    end
`ifdef LOOP_ACC_FLAG_EN
    n_cmp++; if ({bus.acc_first_out, bus.acc_last_out} !== 2'b00) begin n_bad++; $display("FAIL reset_acc: got %b%b want 00", bus.acc_first_out, bus.acc_last_out); end
`endif
    tick();
    rstn = 1'b1;
    repeat (10) tick();
    n_cmp++; if (bus.busy_out !== 1'b0 || bus.w_start_out !== 1'b0 || bus.done_out !== 1'b0) begin
      n_bad++; $display("FAIL idle_after_reset: got busy=%b wstart=%b done=%b want 000", bus.busy_out, bus.w_start_out, bus.done_out);
    end
  endtask

  // full layer: each w_start answered by pass_done 3 cycles later; optionally pokes start during DONE
  task automatic run_layer(input string tag, input bit poke_done_start);
    int  base;
    bit  found;
    int  eo, ei, ew, eh;
    base = ws_count;
    bus.start_in = 1'b1;
    tick();
    bus.start_in = 1'b0;
    for (int p = 1; p <= 72; p++) begin
      found = 1'b0;
      for (int k = 0; k < 20 && !found; k++) begin
        if (bus.w_start_out === 1'b1) found = 1'b1;
        else tick();
      end
      n_cmp++;
      if (!found) begin
        n_bad++; $display("FAIL %s_wstart_timeout: pass %0d got none want pulse", tag, p);
        return;
      end
      eo = (p - 1) % 4;
      ei = ((p - 1) / 4) % 2;
      ew = ((p - 1) / 8) % 3;
      eh = (p - 1) / 24;
      n_cmp++; if (bus.O_CH_MAC_COL_count !== 32'(eo)) begin n_bad++; $display("FAIL %s_o_ch: pass %0d got %0d want %0d", tag, p, bus.O_CH_MAC_COL_count, eo); end
      n_cmp++; if (bus.I_CH_MAC_ROW_count !== 32'(ei)) begin n_bad++; $display("FAIL %s_i_ch: pass %0d got %0d want %0d", tag, p, bus.I_CH_MAC_ROW_count, ei); end
      n_cmp++; if (bus.W_W_count !== 32'(ew)) begin n_bad++; $display("FAIL %s_w_w: pass %0d got %0d want %0d", tag, p, bus.W_W_count, ew); end
      n_cmp++; if (bus.W_H_count !== 32'(eh)) begin n_bad++; $display("FAIL %s_w_h: pass %0d got %0d want %0d", tag, p, bus.W_H_count, eh); end
      n_cmp++; if (bus.busy_out !== 1'b1) begin n_bad++; $display("FAIL %s_busy_issue: pass %0d got %b want 1", tag, p, bus.busy_out); end
      if (p == 5) begin
        n_cmp++; if (bus.O_CH_MAC_COL_count !== 32'd0 || bus.I_CH_MAC_ROW_count !== 32'd1) begin
          n_bad++; $display("FAIL %s_order4: got o=%0d i=%0d want o=0 i=1", tag, bus.O_CH_MAC_COL_count, bus.I_CH_MAC_ROW_count);
        end
      end
      if (p == 9) begin
        n_cmp++; if (bus.W_W_count !== 32'd1 || bus.I_CH_MAC_ROW_count !== 32'd0) begin
          n_bad++; $display("FAIL %s_order8: got w=%0d i=%0d want w=1 i=0", tag, bus.W_W_count, bus.I_CH_MAC_ROW_count);
        end
      end
      if (p == 25) begin
        n_cmp++; if (bus.W_H_count !== 32'd1 || bus.W_W_count !== 32'd0) begin
          n_bad++; $display("FAIL %s_order24: got h=%0d w=%0d want h=1 w=0", tag, bus.W_H_count, bus.W_W_count);
        end
      end
`ifdef LOOP_ACC_FLAG_EN
      n_cmp++; if (bus.acc_first_out !== (p <= 4)) begin n_bad++; $display("FAIL %s_acc_first: pass %0d got %b want %b", tag, p, bus.acc_first_out, (p <= 4)); end
      n_cmp++; if (bus.acc_last_out !== (p >= 69)) begin n_bad++; $display("FAIL %s_acc_last: pass %0d got %b want %b", tag, p, bus.acc_last_out, (p >= 69)); end
`endif
      tick();
      n_cmp++; if (bus.w_start_out !== 1'b0 || bus.busy_out !== 1'b1) begin
        n_bad++; $display("FAIL %s_wait: pass %0d got wstart=%b busy=%b want 0 1", tag, p, bus.w_start_out, bus.busy_out);
      end
      tick();
      tick();
      bus.pass_done_in = 1'b1;
      tick();
      bus.pass_done_in = 1'b0;
      if (p < 72) begin
        n_cmp++; if (bus.w_start_out !== 1'b1) begin n_bad++; $display("FAIL %s_next_latency: pass %0d got %b want 1", tag, p, bus.w_start_out); end
      end else begin
        n_cmp++; if (bus.done_out !== 1'b1 || bus.busy_out !== 1'b0) begin
          n_bad++; $display("FAIL %s_done_pulse: got done=%b busy=%b want 1 0", tag, bus.done_out, bus.busy_out);
        end
        n_cmp++; if (bus.O_CH_MAC_COL_count !== 32'd3 || bus.I_CH_MAC_ROW_count !== 32'd1 || bus.W_W_count !== 32'd2 || bus.W_H_count !== 32'd2) begin
          n_bad++; $display("FAIL %s_done_hold: got %0d %0d %0d %0d want 3 1 2 2", tag,
            bus.O_CH_MAC_COL_count, bus.I_CH_MAC_ROW_count, bus.W_W_count, bus.W_H_count);
        end
`ifdef LOOP_ACC_FLAG_EN
        n_cmp++; if ({bus.acc_first_out, bus.acc_last_out} !== 2'b00) begin n_bad++; $display("FAIL %s_acc_done: got %b%b want 00", tag, bus.acc_first_out, bus.acc_last_out); end
`endif
      end
    end
    if (poke_done_start) bus.start_in = 1'b1;
    tick();
    bus.start_in = 1'b0;
    n_cmp++; if (bus.done_out !== 1'b0 || bus.busy_out !== 1'b0) begin
      n_bad++; $display("FAIL %s_after_done: got done=%b busy=%b want 0 0", tag, bus.done_out, bus.busy_out);
    end
    n_cmp++; if ({bus.O_CH_MAC_COL_count, bus.I_CH_MAC_ROW_count, bus.W_W_count, bus.W_H_count} !== 128'd0) begin
      n_bad++; $display("FAIL %s_counts_clear: got %0d %0d %0d %0d want 0 0 0 0", tag,
        bus.O_CH_MAC_COL_count, bus.I_CH_MAC_ROW_count, bus.W_W_count, bus.W_H_count);
    end
    tick();
    n_cmp++; if (ws_count - base !== 72 || bus.busy_out !== 1'b0) begin
      n_bad++; $display("FAIL %s_pass_total: got %0d busy=%b want 72 busy=0", tag, ws_count - base, bus.busy_out);
    end
  endtask

  task automatic test_full_layer();
    run_layer("full", 1'b1);
  endtask

  task automatic test_spurious();
    int base;
    base = ws_count;
    bus.start_in = 1'b1;
    tick();
    bus.start_in = 1'b0;
    bus.pass_done_in = 1'b1;
    tick();
    bus.pass_done_in = 1'b0;
    n_cmp++; if (bus.O_CH_MAC_COL_count !== 32'd0 || bus.w_start_out !== 1'b0 || bus.busy_out !== 1'b1) begin
      n_bad++; $display("FAIL spur_done_in_issue: got o=%0d wstart=%b busy=%b want 0 0 1", bus.O_CH_MAC_COL_count, bus.w_start_out, bus.busy_out);
    end
    tick();
    bus.start_in = 1'b1;
    tick();
    bus.start_in = 1'b0;
    tick();
    n_cmp++; if (bus.w_start_out !== 1'b0 || bus.busy_out !== 1'b1 || ws_count - base !== 1) begin
      n_bad++; $display("FAIL spur_start_in_wait: got wstart=%b busy=%b passes=%0d want 0 1 1", bus.w_start_out, bus.busy_out, ws_count - base);
    end
    bus.pass_done_in = 1'b1;
    tick();
    bus.pass_done_in = 1'b0;
    n_cmp++; if (bus.w_start_out !== 1'b1 || bus.O_CH_MAC_COL_count !== 32'd1) begin
      n_bad++; $display("FAIL spur_step: got wstart=%b o=%0d want 1 1", bus.w_start_out, bus.O_CH_MAC_COL_count);
    end
    bus.abort_in = 1'b1;
    tick();
    bus.abort_in = 1'b0;
    n_cmp++; if (bus.busy_out !== 1'b0 || bus.O_CH_MAC_COL_count !== 32'd0) begin
      n_bad++; $display("FAIL spur_cleanup: got busy=%b o=%0d want 0 0", bus.busy_out, bus.O_CH_MAC_COL_count);
    end
  endtask

  task automatic test_abort();
    bit found;
    bit seen;
    bus.start_in = 1'b1;
    tick();
    bus.start_in = 1'b0;
    for (int p = 1; p <= 10; p++) begin
      found = 1'b0;
      for (int k = 0; k < 20 && !found; k++) begin
        if (bus.w_start_out === 1'b1) found = 1'b1;
        else tick();
      end
      n_cmp++;
      if (!found) begin n_bad++; $display("FAIL abort_wstart_timeout: pass %0d got none want pulse", p); return; end
      repeat (3) tick();
      bus.pass_done_in = 1'b1;
      tick();
      bus.pass_done_in = 1'b0;
    end
    n_cmp++; if (bus.O_CH_MAC_COL_count !== 32'd2 || bus.I_CH_MAC_ROW_count !== 32'd0 || bus.W_W_count !== 32'd1) begin
      n_bad++; $display("FAIL abort_pass11_idx: got o=%0d i=%0d w=%0d want 2 0 1", bus.O_CH_MAC_COL_count, bus.I_CH_MAC_ROW_count, bus.W_W_count);
    end
    bus.abort_in = 1'b1;
    #1;
    n_cmp++; if (bus.w_start_out !== 1'b0) begin n_bad++; $display("FAIL abort_masks_wstart: got %b want 0", bus.w_start_out); end
    tick();
    bus.abort_in = 1'b0;
    n_cmp++; if (bus.busy_out !== 1'b0 || bus.done_out !== 1'b0) begin
      n_bad++; $display("FAIL abort_idle: got busy=%b done=%b want 0 0", bus.busy_out, bus.done_out);
    end
    n_cmp++; if ({bus.O_CH_MAC_COL_count, bus.I_CH_MAC_ROW_count, bus.W_W_count, bus.W_H_count} !== 128'd0) begin
      n_bad++; $display("FAIL abort_counts: got %0d %0d %0d %0d want 0 0 0 0",
        bus.O_CH_MAC_COL_count, bus.I_CH_MAC_ROW_count, bus.W_W_count, bus.W_H_count);
    end
    seen = 1'b0;
    for (int k = 0; k < 5; k++) begin
      if (bus.done_out === 1'b1 || bus.w_start_out === 1'b1) seen = 1'b1;
      tick();
    end
    n_cmp++; if (seen !== 1'b0) begin n_bad++; $display("FAIL abort_quiet: got pulse=%b want 0", seen); end
    bus.start_in = 1'b1;
    bus.abort_in = 1'b1;
    tick();
    bus.start_in = 1'b0;
    bus.abort_in = 1'b0;
    n_cmp++; if (bus.busy_out !== 1'b0 || bus.w_start_out !== 1'b0) begin
      n_bad++; $display("FAIL start_abort_idle: got busy=%b wstart=%b want 0 0", bus.busy_out, bus.w_start_out);
    end
    run_layer("restart", 1'b0);
  endtask

  task automatic test_reset_mid_layer();
    bus.start_in = 1'b1;
    tick();
    bus.start_in = 1'b0;
    for (int p = 1; p <= 3; p++) begin
      repeat (3) tick();
      bus.pass_done_in = 1'b1;
      tick();
      bus.pass_done_in = 1'b0;
    end
    n_cmp++; if (bus.O_CH_MAC_COL_count !== 32'd3 || bus.busy_out !== 1'b1) begin
      n_bad++; $display("FAIL midrst_pre: got o=%0d busy=%b want 3 1", bus.O_CH_MAC_COL_count, bus.busy_out);
    end
    #2;
    rstn = 1'b0;
    #1;
    n_cmp++; if (bus.busy_out !== 1'b0 || bus.w_start_out !== 1'b0 || bus.O_CH_MAC_COL_count !== 32'd0) begin
      n_bad++; $display("FAIL midrst_async: got busy=%b wstart=%b o=%0d want 0 0 0", bus.busy_out, bus.w_start_out, bus.O_CH_MAC_COL_count);
    end
    tick();
    rstn = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_full_layer();
    test_spurious();
    test_abort();
    test_reset_mid_layer();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
